// File: rtl/shift_left_by_1_pkg.sv
// Shared constants for the shift-left-by-one pipeline stage.
// Default operand and result widths live here so every user of the stage agrees on them.
package shift_left_by_1_pkg;

    localparam int SHL_IN_W  = 32;
    localparam int SHL_OUT_W = 15;

endpackage : shift_left_by_1_pkg

// File: rtl/shift_left_by_1_if.sv
// Valid/ready operand and result channel of the shift-left-by-one stage.
// The slave modport is the stage itself; the master modport is the upstream/downstream side.
interface shift_left_by_1_if
    import shift_left_by_1_pkg::*;
#(
    parameter int IN_W  = SHL_IN_W,
    parameter int OUT_W = SHL_OUT_W
);

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  input_value;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] shifted_output;
    logic             overflow;

    modport slave (
        input  in_valid,
        output in_ready,
        input  input_value,
        output out_valid,
        input  out_ready,
        output shifted_output,
        output overflow
    );

    modport master (
        output in_valid,
        input  in_ready,
        output input_value,
        input  out_valid,
        output out_ready,
        input  shifted_output,
        input  overflow
    );

endinterface : shift_left_by_1_if

// File: rtl/shift_left_by_1.sv
// One-stage pipeline: shifts the operand left by one, truncates to OUT_W bits and
// flags any discarded nonzero bits. Result and flag come only from registers.
module shift_left_by_1
    import shift_left_by_1_pkg::*;
#(
    parameter int IN_W  = SHL_IN_W,
    parameter int OUT_W = SHL_OUT_W
) (
    input logic             clk,
    input logic             rst_n,
    shift_left_by_1_if.slave bus
);

    if (OUT_W < 2 || OUT_W > IN_W) begin : g_bad_width
        $error("shift_left_by_1: OUT_W must satisfy 2 <= OUT_W <= IN_W");
    end

    logic             out_valid_q;
    logic [OUT_W-1:0] result_q;
    logic             overflow_q;

    logic             in_xfer;
    logic [OUT_W-1:0] result_d;
    logic             overflow_d;

    // Skid-free single register: a stalled result blocks new operands, a draining one does not.
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign in_xfer      = bus.in_valid && bus.in_ready;

    assign result_d   = {bus.input_value[OUT_W-2:0], 1'b0};
    assign overflow_d = |bus.input_value[IN_W-1:OUT_W-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
        end else if (in_xfer) begin
            out_valid_q <= 1'b1;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.shifted_output = result_q;
    assign bus.overflow       = overflow_q;

endmodule : shift_left_by_1

// File: tb/tb_shift_left_by_1.sv
// Bench for shift_left_by_1: directed cases plus randomized traffic checked against a
// queue-based scoreboard whose expected values come from plain arithmetic.
module tb_shift_left_by_1;
    import shift_left_by_1_pkg::*;

    localparam int IN_W  = SHL_IN_W;
    localparam int OUT_W = SHL_OUT_W;

    logic clk;
    logic rst_n;

    int n_chk;
    int n_fail;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];

    shift_left_by_1_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    shift_left_by_1 #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] v);
        exp_t e;
        longint unsigned x;
        x     = longint'(v);
        e.res = 32'((x * 2) % (64'd1 << OUT_W));
        e.ovf = (x / (64'd1 << (OUT_W - 1))) != 0;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] r, input logic o);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
        chk({tag, "_res"},   32'(bus.shifted_output), r);
        chk({tag, "_ovf"},   32'(bus.overflow), 32'(o));
    endtask

    task automatic send(input string tag, input logic [31:0] v, input logic [31:0] r, input logic o);
        bus.in_valid    = 1'b1;
        bus.input_value = v;
        bus.out_ready   = 1'b1;
        step();
        bus.in_valid    = 1'b0;
        bus.input_value = $urandom;
        check_out(tag, 1'b1, r, o);
        step();
        chk({tag, "_drain"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n           = 1'b0;
        bus.in_valid    = 1'b1;
        bus.input_value = 32'hFFFF_FFFF;
        bus.out_ready   = 1'b0;
        step();
        step();
        check_out("reset", 1'b0, 32'h0, 1'b0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        step();

        send("basic",  32'h0000_0220, 32'h0440, 1'b0);
        send("ovf21",  32'h0020_0030, 32'h0060, 1'b1);
        send("max",    32'h0000_3FFF, 32'h7FFE, 1'b0);
        send("edge",   32'h0000_4000, 32'h0000, 1'b1);

        // back-to-back
        bus.out_ready   = 1'b1;
        bus.in_valid    = 1'b1;
        bus.input_value = 32'h0000_0033;
        step();
        check_out("b2b_a", 1'b1, 32'h0066, 1'b0);
        chk("b2b_rdy", 32'(bus.in_ready), 32'd1);
        bus.input_value = 32'h0000_0002;
        step();
        check_out("b2b_b", 1'b1, 32'h0004, 1'b0);
        bus.in_valid = 1'b0;
        step();
        chk("b2b_drain", 32'(bus.out_valid), 32'd0);

        // backpressure, then drain with a same-cycle replacement
        bus.out_ready   = 1'b0;
        bus.in_valid    = 1'b1;
        bus.input_value = 32'h0000_0123;
        step();
        bus.input_value = 32'h0000_7FFF;
        for (int i = 0; i < 4; i++) begin
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check_out("bp_hold", 1'b1, 32'h0246, 1'b0);
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(bus.in_ready), 32'd1);
        step();
        check_out("bp_next", 1'b1, 32'h7FFE, 1'b1);
        bus.in_valid = 1'b0;
        step();
        chk("bp_drain", 32'(bus.out_valid), 32'd0);

        // reset while holding a result, with a competing transfer
        bus.out_ready   = 1'b0;
        bus.in_valid    = 1'b1;
        bus.input_value = 32'h0000_0055;
        step();
        check_out("rst_held", 1'b1, 32'h00AA, 1'b0);
        rst_n           = 1'b0;
        bus.out_ready   = 1'b1;
        bus.input_value = 32'h0000_0001;
        step();
        check_out("rst_mid", 1'b0, 32'h0, 1'b0);
        chk("rst_mid_rdy", 32'(bus.in_ready), 32'd1);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        step();

        // randomized traffic against the scoreboard
        for (int c = 0; c < 600; c++) begin
            logic        iv, ordy, acc;
            logic [31:0] v;
            int          sel;
            sel  = $urandom_range(0, 3);
            v    = (sel == 0) ? 32'($urandom_range(0, 32'h7FFF)) :
                   (sel == 1) ? (32'h1 << $urandom_range(0, 31)) : $urandom;
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            bus.in_valid    = iv;
            bus.input_value = v;
            bus.out_ready   = ordy;
            #1;
            chk("rnd_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
            chk("rnd_in_ready", 32'(bus.in_ready), 32'(exp_q.size() == 0 || ordy));
            acc = iv && (exp_q.size() == 0 || ordy);
            if (exp_q.size() != 0 && ordy) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rnd_res", 32'(bus.shifted_output), e.res);
                chk("rnd_ovf", 32'(bus.overflow), 32'(e.ovf));
            end
            if (acc) exp_q.push_back(model(v));
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("final_res", 32'(bus.shifted_output), e.res);
            chk("final_ovf", 32'(bus.overflow), 32'(e.ovf));
        end
        step();
        chk("final_idle", 32'(bus.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_shift_left_by_1

// File: doc/shift_left_by_1.md
SHIFT_LEFT_BY_1 -- requirements
Module: shift_left_by_1

Interface
REQ-001 Parameter IN_W, default 32, width of input_value.
REQ-002 Parameter OUT_W, default 15, width of shifted_output; OUT_W SHALL be at least 2 and less than or equal to IN_W.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 in_valid  input  1  input_value holds a valid operand this cycle.
REQ-006 in_ready  output  1  stage can accept an operand this cycle.
REQ-007 input_value  input  IN_W  operand, typically an immediate or offset word.
REQ-008 out_valid  output  1  shifted_output holds a valid result.
REQ-009 out_ready  input  1  downstream accepts the result this cycle.
REQ-010 shifted_output  output  OUT_W  registered result: operand shifted left by one and truncated.
REQ-011 overflow  output  1  registered flag, qualified by out_valid: nonzero operand bits were discarded.

Function
REQ-012 Result SHALL equal {input_value[OUT_W-2:0], 1'b0}: bit 0 is always 0, and input bits OUT_W-1 and above are dropped.
REQ-013 overflow SHALL be 1 when any of input_value[IN_W-1:OUT_W-1] is nonzero, else 0.
REQ-014 Handshake SHALL be valid/ready, and a transfer occurs on a cycle where valid and ready are both 1.
REQ-015 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-016 On an input transfer, the next rising edge SHALL load shifted_output and overflow and set out_valid to 1, giving a latency of one cycle.
REQ-017 When out_valid is 1 and out_ready is 1 with no input transfer, out_valid SHALL clear on the next edge.
REQ-018 An input transfer and an output transfer in the same cycle SHALL replace the held result with the new one, with no bubble; full throughput is one result per cycle.
REQ-019 While out_valid is 1 and out_ready is 0, shifted_output and overflow SHALL hold stable, and in_ready SHALL be 0.
REQ-020 When in_valid is 0, input_value SHALL be ignored, and the data registers SHALL keep their value.
REQ-021 The design SHALL contain no combinational path from input_value to shifted_output.

Reset
REQ-022 When rst_n is 0 at a rising edge, out_valid, shifted_output and overflow SHALL all become 0, overriding any transfer in that cycle.
REQ-023 Reset mid-operation SHALL discard a held, unaccepted result.
REQ-024 During reset, in_ready SHALL read 1, because out_valid is 0.

Structure
REQ-025 The default widths IN_W=32 and OUT_W=15 SHALL be defined as constants in the shared project package and used as the parameter defaults.
REQ-026 The block SHALL be a single module with no sub-modules, consisting of a combinational shift/overflow path feeding one pipeline register stage.

Verification
REQ-027 Send 0x00000220 with out_ready=1 -> next cycle shifted_output=0x0440, overflow=0, out_valid=1.
REQ-028 Send 0x00200030 -> shifted_output=0x0060, overflow=1 (bit 21 set).
REQ-029 Send 0x00000033 then 0x00000002 back-to-back with out_ready=1 -> results 0x0066 then 0x0004 on consecutive cycles, overflow=0 for both.
REQ-030 Boundary cases:
- Send 0x00003FFF -> result 0x7FFE, overflow=0.
- Send 0x00004000 -> result 0x0000, overflow=1.
REQ-031 Backpressure: hold out_ready=0 after one accepted operand -> in_ready=0 and outputs stable for several cycles; then raise out_ready -> the result drains and the next operand is accepted.
REQ-032 Assert rst_n=0 while a result is held -> at the next edge out_valid=0, shifted_output=0x0000, overflow=0.
